dmem_port_arbiter: RTL and testbench

- Shares the single-port, byte-enabled data memory (synchronous read, 1-cycle latency, 4096-byte space) between two requesters: the core MEM stage and a DMA/debug loader.
- Performs store lane steering (SB/SH/SW) and byte-enable generation for both requesters, then routes read data back to the requester that issued the read.
- Core has fixed priority; a starvation counter forces one DMA grant after a bounded wait.

---
 rtl/dmem_port_arbiter_pkg.sv | 32 +++
 rtl/dmem_port_arbiter_if.sv | 51 +++++
 rtl/dmem_lane_steer.sv | 39 +++
 rtl/dmem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   - access size encodings (func3[1:0] style)
//   - arbiter FSM states
//   - read-return owner codes
//   - request bundle handed to the lane steering logic
package dmem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_X = 2'b11   // illegal size, treated as misaligned
   } size_e;

   typedef enum logic {
      ST_CORE_PRI  = 1'b0,
      ST_DMA_FORCE = 1'b1
   } arb_state_e;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_DMA  = 1'b1
   } owner_e;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic [1:0]  lane;    // addr[1:0] of the winning request
      logic [31:0] wdata;   // LSB-aligned store data
   } steer_req_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two requesters, the memory macro and the arbiter.
//   core_* : core MEM-stage request / stall / read return
//   dma_*  : DMA-debug loader request / grant / read return
//   mem_*  : single-port byte-enabled memory (1-cycle read latency)
//   misalign_err : registered pulse for a misaligned/illegal accepted access
// Modports: master = requesters + memory side, slave = arbiter.
interface dmem_port_arbiter_if #(
   parameter int ADDR_W = 32
) ();
   logic              core_req, core_we;
   logic [1:0]        core_size;
   logic [ADDR_W-1:0] core_addr;
   logic [31:0]       core_wdata;
   logic              core_stall, core_rvalid;
   logic [31:0]       core_rdata;

   logic              dma_req, dma_we;
   logic [1:0]        dma_size;
   logic [ADDR_W-1:0] dma_addr;
   logic [31:0]       dma_wdata;
   logic              dma_gnt, dma_rvalid;
   logic [31:0]       dma_rdata;

   logic              misalign_err;

   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_wen;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport master (
      output core_req, core_we, core_size, core_addr, core_wdata,
      input  core_stall, core_rvalid, core_rdata,
      output dma_req, dma_we, dma_size, dma_addr, dma_wdata,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  misalign_err,
      input  mem_en, mem_addr, mem_wen, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  core_req, core_we, core_size, core_addr, core_wdata,
      output core_stall, core_rvalid, core_rdata,
      input  dma_req, dma_we, dma_size, dma_addr, dma_wdata,
      output dma_gnt, dma_rvalid, dma_rdata,
      output misalign_err,
      output mem_en, mem_addr, mem_wen, mem_wdata,
      input  mem_rdata
   );
endinterface

// File: rtl/dmem_lane_steer.sv
// Store lane steering and byte-enable generation, purely combinational.
//   req      : winning request (we, size, addr[1:0], LSB-aligned wdata)
//   wen      : byte write enables, 0000 for loads and misaligned stores
//   wdata    : data moved onto the addressed byte lanes, other lanes 0
//   misalign : SH on odd address, SW not word aligned, or size 11
module dmem_lane_steer
   import dmem_port_arbiter_pkg::*;
(
   input  steer_req_t  req,
   output logic [3:0]  wen,
   output logic [31:0] wdata,
   output logic        misalign
);
   logic [3:0] wen_raw;

   always_comb begin
      wen_raw  = 4'b0000;
      wdata    = req.wdata;
      misalign = 1'b0;
      case (req.size)
         SZ_B: begin
            wen_raw = 4'b0001 << req.lane;
            wdata   = {24'b0, req.wdata[7:0]} << {req.lane, 3'b000};
         end
         SZ_H: begin
            wen_raw  = 4'b0011 << {req.lane[1], 1'b0};
            wdata    = {16'b0, req.wdata[15:0]} << {req.lane[1], 4'b0000};
            misalign = req.lane[0];
         end
         SZ_W: begin
            wen_raw  = 4'b1111;
            misalign = |req.lane;
         end
         default: misalign = 1'b1;
      endcase
      // misaligned stores are still accepted but must not touch memory
      wen = (req.we && !misalign) ? wen_raw : 4'b0000;
   end
endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: core MEM stage vs DMA/debug loader.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dmem_port_arbiter_if.slave (requests, grants, read return,
//              misalign pulse, memory port)
// Core has fixed priority; after DMA_MAX_WAIT consecutive denied DMA cycles
// one DMA grant is forced. Grants and memory signals are combinational in
// the request cycle; read data is routed back one cycle later.
// Optional: DMEM_ARB_PERF_EN adds perf_core_acc / perf_dma_acc /
// perf_core_stall event counters.
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int DMA_MAX_WAIT = 8,
   parameter int ADDR_W       = 32
) (
   input  logic clk,
   input  logic rst,
   dmem_port_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [31:0] perf_core_acc,
   output logic [31:0] perf_dma_acc,
   output logic [31:0] perf_core_stall
`endif
);
   localparam logic [7:0] WAIT_LAST = 8'(DMA_MAX_WAIT - 1);

   arb_state_e        state_q, state_d, st_eff;
   logic [7:0]        wait_cnt;
   logic              dma_gnt, core_stall, core_acc, mem_en;
   logic              rd_pend_q, mis_q;
   owner_e            rd_owner_q;
   steer_req_t        win;
   logic [ADDR_W-1:0] win_addr;
   logic [3:0]        st_wen;
   logic [31:0]       st_wdata;
   logic              st_mis;

   // reset must act on the grant in the same cycle, not only after the edge
   assign st_eff = rst ? ST_CORE_PRI : state_q;

   always_comb begin
      dma_gnt    = 1'b0;
      core_stall = 1'b0;
      state_d    = ST_CORE_PRI;
      case (st_eff)
         ST_DMA_FORCE: begin
            // if DMA withdrew, the core goes through unstalled
            dma_gnt    = bus.dma_req;
            core_stall = bus.core_req & bus.dma_req;
         end
         default: begin
            dma_gnt = bus.dma_req & ~bus.core_req;
            if (bus.dma_req && !dma_gnt && wait_cnt == WAIT_LAST)
               state_d = ST_DMA_FORCE;
         end
      endcase
   end

   assign core_acc = bus.core_req & ~core_stall;
   assign mem_en   = core_acc | dma_gnt;

   assign win_addr  = dma_gnt ? bus.dma_addr  : bus.core_addr;
   assign win.we    = dma_gnt ? bus.dma_we    : bus.core_we;
   assign win.size  = dma_gnt ? bus.dma_size  : bus.core_size;
   assign win.wdata = dma_gnt ? bus.dma_wdata : bus.core_wdata;
   assign win.lane  = win_addr[1:0];

   dmem_lane_steer u_steer (
      .req      (win),
      .wen      (st_wen),
      .wdata    (st_wdata),
      .misalign (st_mis)
   );

   assign bus.mem_en    = mem_en;
   assign bus.mem_addr  = win_addr;
   assign bus.mem_wen   = mem_en ? st_wen : 4'b0000;
   assign bus.mem_wdata = st_wdata;

   assign bus.core_stall = core_stall;
   assign bus.dma_gnt    = dma_gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_CORE_PRI;
         wait_cnt   <= 8'd0;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= OWN_CORE;
         mis_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (dma_gnt || !bus.dma_req)
            wait_cnt <= 8'd0;
         else if (wait_cnt != 8'hFF)
            wait_cnt <= wait_cnt + 8'd1;
         rd_pend_q  <= mem_en & ~win.we;
         rd_owner_q <= dma_gnt ? OWN_DMA : OWN_CORE;
         mis_q      <= mem_en & st_mis;
      end
   end

   // gating with rst drops a read that was in flight when reset hit
   assign bus.core_rvalid  = rd_pend_q & ~rst & (rd_owner_q == OWN_CORE);
   assign bus.dma_rvalid   = rd_pend_q & ~rst & (rd_owner_q == OWN_DMA);
   assign bus.core_rdata   = bus.core_rvalid ? bus.mem_rdata : 32'h0;
   assign bus.dma_rdata    = bus.dma_rvalid  ? bus.mem_rdata : 32'h0;
   assign bus.misalign_err = mis_q;

`ifdef DMEM_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_core_acc   <= 32'd0;
         perf_dma_acc    <= 32'd0;
         perf_core_stall <= 32'd0;
      end else begin
         if (core_acc)   perf_core_acc   <= perf_core_acc + 32'd1;
         if (dma_gnt)    perf_dma_acc    <= perf_dma_acc + 32'd1;
         if (core_stall) perf_core_stall <= perf_core_stall + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a
// randomized run against a byte-array memory model and a denied-cycle
// starvation model.
module tb_dmem_port_arbiter;
   localparam int MAXW = 8;
   localparam int AW   = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_port_arbiter_if #(.ADDR_W(AW)) bus ();

`ifdef DMEM_ARB_PERF_EN
   logic [31:0] perf_core_acc, perf_dma_acc, perf_core_stall;
`endif

   dmem_port_arbiter #(.DMA_MAX_WAIT(MAXW), .ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef DMEM_ARB_PERF_EN
      ,
      .perf_core_acc   (perf_core_acc),
      .perf_dma_acc    (perf_dma_acc),
      .perf_core_stall (perf_core_stall)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   // memory macro: synchronous read, byte-enabled write, cleared by rst
   logic [31:0] tmem [0:1023];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) tmem[i] <= 32'h0;
      end else if (bus.mem_en) begin
         for (int i = 0; i < 4; i++)
            if (bus.mem_wen[i]) tmem[bus.mem_addr[11:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
         if (bus.mem_wen == 4'b0000) bus.mem_rdata <= tmem[bus.mem_addr[11:2]];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic idle();
      bus.core_req = 0; bus.core_we = 0; bus.core_size = 2'b10; bus.core_addr = '0; bus.core_wdata = '0;
      bus.dma_req  = 0; bus.dma_we  = 0; bus.dma_size  = 2'b10; bus.dma_addr  = '0; bus.dma_wdata  = '0;
   endtask

   task automatic core_op(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      bus.core_req = 1; bus.core_we = we; bus.core_size = sz; bus.core_addr = a; bus.core_wdata = d;
   endtask

   task automatic dma_op(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      bus.dma_req = 1; bus.dma_we = we; bus.dma_size = sz; bus.dma_addr = a; bus.dma_wdata = d;
   endtask

   task automatic test_reset();
      rst = 1; idle();
      core_op(0, 2'b10, 32'h10, 0); dma_op(0, 2'b10, 32'h20, 0);
      #1;
      n_tests++; if (bus.core_stall !== 1'b0) begin n_fail++; $display("FAIL rst_core_stall: got %b want 0", bus.core_stall); end
      n_tests++; if (bus.dma_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_dma_gnt: got %b want 0", bus.dma_gnt); end
      @(negedge clk); #1;
      n_tests++; if (bus.core_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_core_rvalid: got %b want 0", bus.core_rvalid); end
      n_tests++; if (bus.dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_dma_rvalid: got %b want 0", bus.dma_rvalid); end
      n_tests++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b want 0", bus.misalign_err); end
      @(negedge clk); rst = 0; idle(); #1;
      n_tests++; if (bus.core_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL post_rst_rvalid: got %b%b want 00", bus.core_rvalid, bus.dma_rvalid); end
      n_tests++; if (bus.mem_en !== 1'b0 || bus.mem_wen !== 4'b0000) begin n_fail++; $display("FAIL idle_mem: got en=%b wen=%b want 0/0000", bus.mem_en, bus.mem_wen); end
      @(negedge clk);
   endtask

   task automatic test_store_lanes();
      idle(); core_op(1, 2'b10, 32'h10, 32'hA1B2C3D4); #1;
      n_tests++; if (bus.core_stall !== 1'b0) begin n_fail++; $display("FAIL sw_stall: got %b want 0", bus.core_stall); end
      n_tests++; if (bus.mem_en !== 1'b1) begin n_fail++; $display("FAIL sw_en: got %b want 1", bus.mem_en); end
      n_tests++; if (bus.mem_wen !== 4'b1111) begin n_fail++; $display("FAIL sw_wen: got %b want 1111", bus.mem_wen); end
      n_tests++; if (bus.mem_wdata !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL sw_wdata: got %h want a1b2c3d4", bus.mem_wdata); end
      @(negedge clk); core_op(0, 2'b10, 32'h10, 0); #1;
      n_tests++; if (bus.mem_wen !== 4'b0000 || bus.mem_en !== 1'b1) begin n_fail++; $display("FAIL lw_mem: got en=%b wen=%b want 1/0000", bus.mem_en, bus.mem_wen); end
      @(negedge clk); core_op(1, 2'b00, 32'h13, 32'h000000EE); #1;
      n_tests++; if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL lw_ret: got v=%b d=%h want 1/a1b2c3d4", bus.core_rvalid, bus.core_rdata); end
      n_tests++; if (bus.dma_rvalid !== 1'b0 || bus.dma_rdata !== 32'h0) begin n_fail++; $display("FAIL lw_dma_quiet: got v=%b d=%h want 0/0", bus.dma_rvalid, bus.dma_rdata); end
      n_tests++; if (bus.mem_wen !== 4'b1000) begin n_fail++; $display("FAIL sb_wen: got %b want 1000", bus.mem_wen); end
      n_tests++; if (bus.mem_wdata !== 32'hEE000000) begin n_fail++; $display("FAIL sb_wdata: got %h want ee000000", bus.mem_wdata); end
      @(negedge clk); core_op(1, 2'b01, 32'h12, 32'h00001234); #1;
      n_tests++; if (bus.mem_wen !== 4'b1100) begin n_fail++; $display("FAIL sh_wen: got %b want 1100", bus.mem_wen); end
      n_tests++; if (bus.mem_wdata !== 32'h12340000) begin n_fail++; $display("FAIL sh_wdata: got %h want 12340000", bus.mem_wdata); end
      @(negedge clk); core_op(0, 2'b10, 32'h10, 0); #1;
      @(negedge clk); idle(); #1;
      n_tests++; if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== 32'h1234C3D4) begin n_fail++; $display("FAIL sbsh_readback: got v=%b d=%h want 1/1234c3d4", bus.core_rvalid, bus.core_rdata); end
      @(negedge clk);
   endtask

   task automatic test_misalign();
      idle(); core_op(1, 2'b10, 32'h11, 32'hDEADBEEF); #1;
      n_tests++; if (bus.mem_en !== 1'b1 || bus.core_stall !== 1'b0) begin n_fail++; $display("FAIL mis_sw_accept: got en=%b stall=%b want 1/0", bus.mem_en, bus.core_stall); end
      n_tests++; if (bus.mem_wen !== 4'b0000) begin n_fail++; $display("FAIL mis_sw_wen: got %b want 0000", bus.mem_wen); end
      n_tests++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_early: got %b want 0", bus.misalign_err); end
      @(negedge clk); core_op(1, 2'b11, 32'h10, 32'hFFFFFFFF); #1;
      n_tests++; if (bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_sw_pulse: got %b want 1", bus.misalign_err); end
      n_tests++; if (bus.mem_wen !== 4'b0000) begin n_fail++; $display("FAIL mis_sz11_wen: got %b want 0000", bus.mem_wen); end
      @(negedge clk); core_op(1, 2'b01, 32'h11, 32'h0000AAAA); #1;
      n_tests++; if (bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_sz11_pulse: got %b want 1", bus.misalign_err); end
      n_tests++; if (bus.mem_wen !== 4'b0000) begin n_fail++; $display("FAIL mis_sh_wen: got %b want 0000", bus.mem_wen); end
      @(negedge clk); core_op(0, 2'b10, 32'h10, 0); #1;
      n_tests++; if (bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_sh_pulse: got %b want 1", bus.misalign_err); end
      @(negedge clk); idle(); #1;
      n_tests++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b want 0", bus.misalign_err); end
      n_tests++; if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== 32'h1234C3D4) begin n_fail++; $display("FAIL mis_unchanged: got v=%b d=%h want 1/1234c3d4", bus.core_rvalid, bus.core_rdata); end
      @(negedge clk);
   endtask

   task automatic test_starvation();
      idle(); core_op(0, 2'b10, 32'h40, 0); dma_op(0, 2'b10, 32'h80, 0);
      for (int k = 0; k < 18; k++) begin
         #1;
         n_tests++; if (bus.dma_gnt !== ((k % 9) == 8)) begin n_fail++; $display("FAIL starve_gnt[%0d]: got %b want %b", k, bus.dma_gnt, ((k % 9) == 8)); end
         n_tests++; if (bus.core_stall !== ((k % 9) == 8)) begin n_fail++; $display("FAIL starve_stall[%0d]: got %b want %b", k, bus.core_stall, ((k % 9) == 8)); end
         @(negedge clk);
      end
      idle();
   endtask

   task automatic test_back_to_back();
      idle(); core_op(1, 2'b10, 32'h20, 32'h11223344); #1;
      @(negedge clk); idle(); dma_op(1, 2'b10, 32'h24, 32'hCAFEF00D); #1;
      n_tests++; if (bus.dma_gnt !== 1'b1 || bus.mem_wen !== 4'b1111) begin n_fail++; $display("FAIL dma_sw: got gnt=%b wen=%b want 1/1111", bus.dma_gnt, bus.mem_wen); end
      @(negedge clk); idle(); core_op(0, 2'b10, 32'h20, 0); #1;
      @(negedge clk); idle(); dma_op(0, 2'b10, 32'h24, 0); #1;
      n_tests++; if (bus.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_dma_gnt: got %b want 1", bus.dma_gnt); end
      n_tests++; if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== 32'h11223344) begin n_fail++; $display("FAIL b2b_core_ret: got v=%b d=%h want 1/11223344", bus.core_rvalid, bus.core_rdata); end
      n_tests++; if (bus.dma_rvalid !== 1'b0 || bus.dma_rdata !== 32'h0) begin n_fail++; $display("FAIL b2b_dma_quiet: got v=%b d=%h want 0/0", bus.dma_rvalid, bus.dma_rdata); end
      @(negedge clk); idle(); #1;
      n_tests++; if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_dma_ret: got v=%b d=%h want 1/cafef00d", bus.dma_rvalid, bus.dma_rdata); end
      n_tests++; if (bus.core_rvalid !== 1'b0 || bus.core_rdata !== 32'h0) begin n_fail++; $display("FAIL b2b_core_quiet: got v=%b d=%h want 0/0", bus.core_rvalid, bus.core_rdata); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      idle(); dma_op(0, 2'b10, 32'h24, 0); #1;
      n_tests++; if (bus.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt: got %b want 1", bus.dma_gnt); end
      @(negedge clk); rst = 1; idle(); #1;
      n_tests++; if (bus.dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_drop: got %b want 0", bus.dma_rvalid); end
      @(negedge clk); rst = 0; #1;
      n_tests++; if (bus.dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_after: got %b want 0", bus.dma_rvalid); end
      @(negedge clk);
      // drive the arbiter into the forced-DMA cycle, then reset inside it
      core_op(0, 2'b10, 32'h40, 0); dma_op(0, 2'b10, 32'h80, 0);
      for (int k = 0; k < 8; k++) @(negedge clk);
      rst = 1; #1;
      n_tests++; if (bus.dma_gnt !== 1'b0 || bus.core_stall !== 1'b0) begin n_fail++; $display("FAIL rmid_force: got gnt=%b stall=%b want 0/0", bus.dma_gnt, bus.core_stall); end
      @(negedge clk); rst = 0;
      for (int k = 0; k < 9; k++) begin
         #1;
         n_tests++; if (bus.dma_gnt !== (k == 8)) begin n_fail++; $display("FAIL rmid_wait[%0d]: got %b want %b", k, bus.dma_gnt, (k == 8)); end
         @(negedge clk);
      end
      idle();
   endtask

   task automatic rand_req(output logic we, output logic [1:0] sz, output logic [31:0] a, output logic [31:0] d);
      int s;
      s  = $urandom_range(0, 7);
      sz = (s < 2) ? 2'b00 : (s < 4) ? 2'b01 : (s < 7) ? 2'b10 : 2'b11;
      we = $urandom_range(0, 1) == 1;
      a  = $urandom_range(0, 4095);
      if ($urandom_range(0, 3) != 0) begin
         if (sz == 2'b01) a[0] = 1'b0;
         if (sz == 2'b10) a[1:0] = 2'b00;
      end
      d  = $urandom;
   endtask

   task automatic test_random();
      logic [7:0]  ref_mem [0:4095];
      logic        pc_v, pd_v, pc_we, pd_we, we;
      logic [1:0]  pc_sz, pd_sz, sz;
      logic [31:0] pc_a, pd_a, pc_d, pd_d, a, d, exp_w, wd;
      logic [3:0]  wen;
      logic        exp_rc, exp_rd, exp_me, frc, g_d, s_c, a_c, mis;
      int          denied, nb, b, lane, base;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h0;
      pc_v = 0; pd_v = 0; exp_rc = 0; exp_rd = 0; exp_me = 0; exp_w = 0; frc = 0; denied = 0;
      pc_we = 0; pd_we = 0; pc_sz = 0; pd_sz = 0; pc_a = 0; pd_a = 0; pc_d = 0; pd_d = 0;
      rst = 1; idle(); @(negedge clk); rst = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!pc_v && $urandom_range(0, 2) != 0) begin pc_v = 1; rand_req(pc_we, pc_sz, pc_a, pc_d); end
         if (!pd_v && $urandom_range(0, 1) != 0) begin pd_v = 1; rand_req(pd_we, pd_sz, pd_a, pd_d); end
         bus.core_req = pc_v; bus.core_we = pc_we; bus.core_size = pc_sz; bus.core_addr = pc_a; bus.core_wdata = pc_d;
         bus.dma_req  = pd_v; bus.dma_we  = pd_we; bus.dma_size  = pd_sz; bus.dma_addr  = pd_a; bus.dma_wdata  = pd_d;
         #1;
         n_tests++; if (bus.core_rvalid !== exp_rc || bus.dma_rvalid !== exp_rd) begin n_fail++; $display("FAIL rnd_rvalid[%0d]: got %b%b want %b%b", cyc, bus.core_rvalid, bus.dma_rvalid, exp_rc, exp_rd); end
         if (exp_rc) begin n_tests++; if (bus.core_rdata !== exp_w) begin n_fail++; $display("FAIL rnd_core_rdata[%0d]: got %h want %h", cyc, bus.core_rdata, exp_w); end end
         if (exp_rd) begin n_tests++; if (bus.dma_rdata !== exp_w) begin n_fail++; $display("FAIL rnd_dma_rdata[%0d]: got %h want %h", cyc, bus.dma_rdata, exp_w); end end
         n_tests++; if (bus.misalign_err !== exp_me) begin n_fail++; $display("FAIL rnd_misalign[%0d]: got %b want %b", cyc, bus.misalign_err, exp_me); end
         // who wins this cycle
         if (frc) begin g_d = pd_v; s_c = pc_v && pd_v; end
         else     begin g_d = pd_v && !pc_v; s_c = 1'b0; end
         a_c = pc_v && !s_c;
         n_tests++; if (bus.dma_gnt !== g_d || bus.core_stall !== s_c) begin n_fail++; $display("FAIL rnd_arb[%0d]: got gnt=%b stall=%b want %b/%b", cyc, bus.dma_gnt, bus.core_stall, g_d, s_c); end
         n_tests++; if (bus.mem_en !== (a_c || g_d)) begin n_fail++; $display("FAIL rnd_en[%0d]: got %b want %b", cyc, bus.mem_en, (a_c || g_d)); end
         exp_rc = 0; exp_rd = 0; exp_me = 0;
         if (a_c || g_d) begin
            we = g_d ? pd_we : pc_we; sz = g_d ? pd_sz : pc_sz; a = g_d ? pd_a : pc_a; d = g_d ? pd_d : pc_d;
            nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
            wen = 4'b0000; wd = 32'h0;
            if (we && !mis)
               for (int i = 0; i < nb; i++) begin
                  b = int'(a[11:0]) + i; lane = b % 4;
                  wen[lane] = 1'b1; wd[8*lane +: 8] = d[8*i +: 8]; ref_mem[b] = d[8*i +: 8];
               end
            n_tests++; if (bus.mem_addr !== a) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", cyc, bus.mem_addr, a); end
            n_tests++; if (bus.mem_wen !== wen) begin n_fail++; $display("FAIL rnd_wen[%0d]: got %b want %b", cyc, bus.mem_wen, wen); end
            if (wen != 4'b0000) begin n_tests++; if (bus.mem_wdata !== wd) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h want %h", cyc, bus.mem_wdata, wd); end end
            if (!we) begin
               base  = int'(a[11:2]) * 4;
               exp_w = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
               exp_rc = !g_d; exp_rd = g_d;
            end
            exp_me = mis;
         end
         // DMA forced in after MAXW back-to-back denied cycles
         if (pd_v && !g_d) denied++; else denied = 0;
         frc = !frc && (denied == MAXW);
         if (a_c) pc_v = 0;
         if (g_d) pd_v = 0;
         @(negedge clk);
      end
      idle(); #1;
      n_tests++; if (bus.core_rvalid !== exp_rc || bus.dma_rvalid !== exp_rd) begin n_fail++; $display("FAIL rnd_tail_rvalid: got %b%b want %b%b", bus.core_rvalid, bus.dma_rvalid, exp_rc, exp_rd); end
      if (exp_rc || exp_rd) begin n_tests++; if ((bus.core_rdata | bus.dma_rdata) !== exp_w) begin n_fail++; $display("FAIL rnd_tail_rdata: got %h want %h", bus.core_rdata | bus.dma_rdata, exp_w); end end
      @(negedge clk);
   endtask

   initial begin
      rst = 1; idle();
      @(negedge clk);
      test_reset();
      test_store_lanes();
      test_misalign();
      test_starvation();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
